// File: rtl/kyber_ahb_mst.sv
// kyber_ahb_mst
// AHB-Lite master that runs one Kyber job per start request.
// A job writes MSG_WORDS message words to the peripheral data register,
// then reads CT_WORDS ciphertext words back and hands each one to a
// valid/ready sink. Every transfer is a non-pipelined SINGLE: the address
// phase and the data phase of one transfer never overlap with another
// transfer.
`timescale 1ns/1ps
module kyber_ahb_mst #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MSG_WORDS = 8,
    parameter int          CT_WORDS  = 392
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [31:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [31:0] ct_data,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hrdata,
    input  logic [1:0]  hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    // Terminal counts in the counters' own widths; the compare is equality,
    // so a counter can never run past its terminal value and wrap.
    localparam logic [7:0] LP_MSG_LAST = 8'(MSG_WORDS);
    localparam logic [9:0] LP_CT_LAST  = 10'(CT_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WA,
        WD,
        RA,
        RD,
        HOLD,
        FIN
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wcnt;
    logic [9:0]  r_rcnt;
    logic [31:0] r_hwdata;
    logic [31:0] r_ct_data;
    logic        r_ct_valid;
    logic        r_err;

    state_t      w_state_nxt;
    logic [7:0]  w_wcnt_nxt;
    logic [9:0]  w_rcnt_nxt;
    logic [31:0] w_hwdata_nxt;
    logic [31:0] w_ct_data_nxt;
    logic        w_ct_valid_nxt;
    logic        w_err_nxt;
    logic        w_msg_ready;
    logic [1:0]  w_htrans;
    logic        w_hwrite;
    logic        w_resp_ok;

    assign w_resp_ok = (hresp == HRESP_OKAY);

    // Register the state, counters and the datapath registers feeding the bus and the sink.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= IDLE;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_hwdata   <= '0;
            r_ct_data  <= '0;
            r_ct_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_hwdata   <= w_hwdata_nxt;
            r_ct_data  <= w_ct_data_nxt;
            r_ct_valid <= w_ct_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Decode next state, next register values and the bus/handshake controls.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement leaves one unassigned (no latches).
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_rcnt_nxt     = r_rcnt;
        w_hwdata_nxt   = r_hwdata;
        w_ct_data_nxt  = r_ct_data;
        w_ct_valid_nxt = r_ct_valid;
        w_err_nxt      = r_err;
        w_msg_ready    = 1'b0;
        w_htrans       = HTRANS_IDLE;
        w_hwrite       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = WA;
                end
            end
            WA: begin
                w_hwrite = 1'b1;
                // No message word: keep the bus idle instead of issuing a write
                // whose data phase could not be supplied.
                if (msg_valid) begin
                    w_htrans = HTRANS_NONSEQ;
                    if (hready) begin
                        w_msg_ready  = 1'b1;
                        w_hwdata_nxt = msg_data;
                        w_state_nxt  = WD;
                    end
                end
            end
            WD: begin
                if (!w_resp_ok) begin
                    w_err_nxt   = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (hready) begin
                    if (r_wcnt + 8'd1 == LP_MSG_LAST) begin
                        w_wcnt_nxt  = '0;
                        w_state_nxt = RA;
                    end else begin
                        w_wcnt_nxt  = r_wcnt + 8'd1;
                        w_state_nxt = WA;
                    end
                end
            end
            RA: begin
                w_htrans = HTRANS_NONSEQ;
                if (hready) begin
                    w_state_nxt = RD;
                end
            end
            RD: begin
                // An errored read is dropped: ct_valid is never raised for it.
                if (!w_resp_ok) begin
                    w_err_nxt   = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (hready) begin
                    w_ct_data_nxt  = hrdata;
                    w_ct_valid_nxt = 1'b1;
                    w_rcnt_nxt     = r_rcnt + 10'd1;
                    w_state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (ct_ready) begin
                    w_ct_valid_nxt = 1'b0;
                    w_state_nxt    = (r_rcnt == LP_CT_LAST) ? FIN : RA;
                end
            end
            FIN: begin
                w_wcnt_nxt  = '0;
                w_rcnt_nxt  = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_wcnt_nxt  = '0;
                w_rcnt_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Only one target register exists, so the address never changes.
    assign haddr     = BASE_ADDR;
    assign htrans    = w_htrans;
    assign hwrite    = w_hwrite;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hwdata    = r_hwdata;
    assign msg_ready = w_msg_ready;
    assign ct_data   = r_ct_data;
    assign ct_valid  = r_ct_valid;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);
    assign err       = r_err;

endmodule

// File: tb/tb_kyber_ahb_mst.sv
// tb_kyber_ahb_mst
// Bench for kyber_ahb_mst: a message source, a ciphertext sink and an AHB
// slave with random wait states and error injection drive the master.
// Expected write words, read words and job outcomes are queued as the
// stimulus is issued; a monitor pops and compares them as the DUT acts.
`timescale 1ns/1ps
module tb_kyber_ahb_mst;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          MW   = 3;
    localparam int          CW   = 4;
    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_NONSEQ = 2'b10;

    logic        hclk      = 1'b0;
    logic        hresetn   = 1'b0;
    logic        start     = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] msg_data  = 32'h1111_1111;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [31:0] ct_data;
    logic        ct_valid;
    logic        ct_ready  = 1'b0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready    = 1'b1;
    logic [31:0] hrdata    = '0;
    logic [1:0]  hresp     = 2'b00;

    int n_checks = 0;
    int n_fails  = 0;

    // Scoreboard queues: words the master must write, words it must hand to
    // the sink, and job outcomes (1 = done pulse, 0 = error).
    logic [31:0] exp_wr[$];
    logic [31:0] exp_ct[$];
    bit          exp_end[$];

    // Stimulus knobs, set by the main sequence between jobs.
    int msg_pct    = 100;
    int ct_pct     = 100;
    int wait_max   = 0;
    int fixed_wait = -1;
    int err_at     = -1;
    bit src_en     = 1'b1;
    bit sink_en    = 1'b1;

    // Slave state, visible to the main sequence for the mid-transfer reset.
    bit s_data  = 1'b0;
    bit s_write = 1'b0;
    int s_wait  = 0;
    int s_idx   = 0;

    kyber_ahb_mst #(
        .BASE_ADDR(BASE),
        .MSG_WORDS(MW),
        .CT_WORDS (CW)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .msg_data (msg_data),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .ct_data  (ct_data),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hwdata   (hwdata),
        .hready   (hready),
        .hrdata   (hrdata),
        .hresp    (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fails++;
        $display("FAIL %s: got 0x%08h, required nothing pending (t=%0t)", name, act, $time);
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    endtask

    // Message source: holds a random word until it is accepted.
    initial begin : source
        bit acc;
        forever begin
            @(negedge hclk);
            acc = hresetn && msg_valid && msg_ready;
            if (acc) exp_wr.push_back(msg_data);
            @(posedge hclk);
            #1;
            if (acc) begin
                msg_data  = $urandom;
                msg_valid = 1'b0;
            end
            if (!src_en) msg_valid = 1'b0;
            else if (!msg_valid) msg_valid = ($urandom_range(1, 100) <= 32'(msg_pct));
        end
    end

    // Ciphertext sink with random back-pressure.
    initial begin : sink
        forever begin
            @(posedge hclk);
            #1;
            ct_ready = sink_en && ($urandom_range(1, 100) <= 32'(ct_pct));
        end
    end

    // AHB slave: one data phase per accepted address phase, random waits,
    // optional error on transfer number err_at of the current job.
    initial begin : slave
        bit a_acc;
        bit a_wr;
        bit d_end;
        forever begin
            @(negedge hclk);
            a_acc = hresetn && (htrans == T_NONSEQ) && hready;
            a_wr  = hwrite;
            d_end = hresetn && s_data && hready;
            if (d_end && !s_write && hresp == 2'b00) exp_ct.push_back(hrdata);
            if (hresetn && start && !busy) s_idx = 0;
            @(posedge hclk);
            #1;
            if (!hresetn) begin
                s_data = 1'b0;
            end else begin
                if (d_end) begin
                    s_data = 1'b0;
                    s_idx++;
                end
                if (a_acc) begin
                    s_data  = 1'b1;
                    s_write = a_wr;
                    s_wait  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
                end
            end
            if (s_data) begin
                hready = (s_wait == 0);
                if (s_wait > 0) s_wait--;
                hresp  = (hready && s_idx == err_at) ? 2'b01 : 2'b00;
                hrdata = $urandom;
            end else begin
                hready = 1'b1;
                hresp  = 2'b00;
            end
        end
    end

    // Monitor: bus rules, data-phase contents, sink handshakes, job outcomes.
    initial begin : monitor
        bit          m_data  = 1'b0;
        bit          m_write = 1'b0;
        bit          m_ctv   = 1'b0;
        logic [31:0] m_ct    = '0;
        bit          m_done  = 1'b0;
        bit          m_err   = 1'b0;
        int          n_wr    = 0;
        int          n_rd    = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                m_data = 1'b0;
                m_ctv  = 1'b0;
                m_done = 1'b0;
                m_err  = 1'b0;
            end else begin
                if (htrans == T_NONSEQ) begin
                    check("nonseq_haddr", haddr, BASE);
                    check("nonseq_hsize", 32'(hsize), 32'd2);
                    check("nonseq_hburst", 32'(hburst), 32'd0);
                    if (hwrite) check("nonseq_wr_needs_msg_valid", 32'(msg_valid), 32'd1);
                end
                if (msg_ready) check("msg_ready_needs_valid", 32'(msg_valid), 32'd1);
                if (ct_valid) check("hold_bus_idle", 32'(htrans), 32'(T_IDLE));
                if (m_ctv) begin
                    check("hold_ct_valid", 32'(ct_valid), 32'd1);
                    check("hold_ct_data", ct_data, m_ct);
                end
                if (m_data && m_write) begin
                    if (exp_wr.size() == 0) fail_now("wr_unexpected", hwdata);
                    else begin
                        check("wr_hwdata", hwdata, exp_wr[0]);
                        if (hready) begin
                            void'(exp_wr.pop_front());
                            n_wr++;
                        end
                    end
                end
                if (m_data && !m_write && hready && hresp == 2'b00) n_rd++;
                if (ct_valid && ct_ready) begin
                    if (exp_ct.size() == 0) fail_now("ct_unexpected", ct_data);
                    else check("ct_data", ct_data, exp_ct.pop_front());
                end
                if (done) begin
                    check("done_one_cycle", 32'(m_done), 32'd0);
                    check("done_busy", 32'(busy), 32'd1);
                    if (exp_end.size() == 0) fail_now("done_unexpected", 32'(done));
                    else check("done_expected", 32'd1, 32'(exp_end.pop_front()));
                    check("done_writes", 32'(n_wr), 32'(MW));
                    check("done_reads", 32'(n_rd), 32'(CW));
                end
                if (err && !m_err) begin
                    check("err_no_done", 32'(done), 32'd0);
                    if (exp_end.size() == 0) fail_now("err_unexpected", 32'(err));
                    else check("err_expected", 32'd0, 32'(exp_end.pop_front()));
                end
                if (start && !busy) begin
                    n_wr = 0;
                    n_rd = 0;
                end
                if (m_data && (hready || hresp != 2'b00)) m_data = 1'b0;
                if (htrans == T_NONSEQ && hready) begin
                    m_data  = 1'b1;
                    m_write = hwrite;
                end
                m_ctv  = ct_valid && !ct_ready;
                m_ct   = ct_data;
                m_done = done;
                m_err  = err;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_htrans"},    32'(htrans),    32'd0);
        check({tag, "_haddr"},     haddr,          BASE);
        check({tag, "_hwrite"},    32'(hwrite),    32'd0);
        check({tag, "_hwdata"},    hwdata,         32'd0);
        check({tag, "_ct_data"},   ct_data,        32'd0);
        check({tag, "_ct_valid"},  32'(ct_valid),  32'd0);
        check({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
    endtask

    task automatic start_job(input bit exp_done);
        @(posedge hclk);
        #2;
        start = 1'b1;
        exp_end.push_back(exp_done);
        @(posedge hclk);
        #2;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_cleared", 32'(err), 32'd0);
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge hclk);
            #2;
            cyc++;
        end
        if (busy) begin
            n_checks++;
            n_fails++;
            $display("FAIL job_timeout: busy=1 after %0d cycles, required 0", cyc);
            finish_test();
        end
    endtask

    initial begin : main
        int cyc;
        int k;
        logic [31:0] held;

        repeat (3) @(posedge hclk);
        #2;
        check_reset_values("rst");
        hresetn = 1'b1;

        // No transfer may appear before the first start.
        repeat (5) begin
            @(posedge hclk);
            #2;
            check("pre_start_htrans", 32'(htrans), 32'(T_IDLE));
        end

        // Back-to-back job with everything ready: 2 cycles/write, 3/read, plus FIN.
        start_job(1'b1);
        wait_end(cyc);
        check("latency_cycles", 32'(cyc), 32'(2 * MW + 3 * CW + 1));
        check("job1_err", 32'(err), 32'd0);

        // Three wait states on every data phase.
        fixed_wait = 3;
        start_job(1'b1);
        wait_end(cyc);
        fixed_wait = -1;

        // Message source stalled for 5 cycles in the write address state.
        src_en = 1'b0;
        @(posedge hclk);
        #2;
        start_job(1'b1);
        repeat (5) begin
            @(posedge hclk);
            #2;
            check("stall_htrans", 32'(htrans), 32'(T_IDLE));
            check("stall_msg_ready", 32'(msg_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        src_en = 1'b1;
        wait_end(cyc);

        // Sink stalled for 4 cycles with a ciphertext word pending.
        sink_en = 1'b0;
        start_job(1'b1);
        k = 0;
        while (!ct_valid && k < 200) begin
            @(posedge hclk);
            #2;
            k++;
        end
        check("hold_reached", 32'(ct_valid), 32'd1);
        held = ct_data;
        repeat (4) begin
            @(posedge hclk);
            #2;
            check("hold_valid_stable", 32'(ct_valid), 32'd1);
            check("hold_data_stable", ct_data, held);
            check("hold_no_nonseq", 32'(htrans), 32'(T_IDLE));
        end
        sink_en = 1'b1;
        wait_end(cyc);

        // Error on the second read, then a clean job that clears err.
        err_at = MW + 1;
        start_job(1'b0);
        wait_end(cyc);
        check("rd_err_sticky", 32'(err), 32'd1);
        err_at = -1;
        start_job(1'b1);
        wait_end(cyc);
        check("rd_err_recovered", 32'(err), 32'd0);

        // Error on the second write.
        err_at = 1;
        start_job(1'b0);
        wait_end(cyc);
        check("wr_err_sticky", 32'(err), 32'd1);
        err_at = -1;

        // Reset during a write data phase, then a full job from word 0.
        start_job(1'b1);
        k = 0;
        while (!(s_data && s_write) && k < 200) begin
            @(posedge hclk);
            #2;
            k++;
        end
        check("wd_reached", 32'(s_data && s_write), 32'd1);
        hresetn = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge hclk);
        #2;
        exp_wr.delete();
        exp_ct.delete();
        exp_end.delete();
        @(posedge hclk);
        #2;
        hresetn = 1'b1;
        start_job(1'b1);
        wait_end(cyc);
        check("post_rst_err", 32'(err), 32'd0);

        // Randomised jobs with back-pressure, waits and occasional errors.
        for (int j = 0; j < 12; j++) begin
            msg_pct  = int'($urandom_range(40, 100));
            ct_pct   = int'($urandom_range(40, 100));
            wait_max = int'($urandom_range(0, 3));
            err_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, MW + CW - 1)) : -1;
            start_job(err_at < 0);
            wait_end(cyc);
            check("rand_err", 32'(err), (err_at >= 0) ? 32'd1 : 32'd0);
        end
        err_at = -1;

        repeat (3) @(posedge hclk);
        #2;
        check("end_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("end_ct_queue_empty", 32'(exp_ct.size()), 32'd0);
        check("end_outcome_queue_empty", 32'(exp_end.size()), 32'd0);
        finish_test();
    end

endmodule
